// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, field bit positions and reset constants.
package cp0_pkg;

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;
    localparam logic [4:0] ADDR_CONFIG   = 5'd16;

    localparam int unsigned IE_BIT     = 0;
    localparam int unsigned EXL_BIT    = 1;
    localparam int unsigned IM_LO      = 8;
    localparam int unsigned IM_HI      = 15;
    localparam int unsigned BEV_BIT    = 22;
    localparam int unsigned EXCCODE_LO = 2;
    localparam int unsigned EXCCODE_HI = 6;
    localparam int unsigned IP_S_LO    = 8;
    localparam int unsigned IP_S_HI    = 9;
    localparam int unsigned IP_H_LO    = 10;
    localparam int unsigned IP_H_HI    = 15;
    localparam int unsigned TI_BIT     = 30;
    localparam int unsigned BD_BIT     = 31;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;

    // Only sel 0 is mapped.
    function automatic logic cp0_hit(input logic [7:0] addr, input logic [4:0] rd);
        return (addr[7:3] == rd) && (addr[2:0] == 3'd0);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: Count prescaler, Count and Compare registers, and the sticky timer-interrupt flag.
module cp0_timer #(
    parameter int unsigned CountDiv = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam int unsigned PrescW = (CountDiv > 1) ? $clog2(CountDiv) : 1;
    localparam logic [PrescW-1:0] PrescLast = PrescW'(CountDiv - 1);

    logic [PrescW-1:0] presc_q, presc_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       compare_q, compare_d;
    logic              ti_q, ti_d;

    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        if (presc_q == PrescLast) begin
            presc_d = '0;
            count_d = count_q + 32'd1;
        end else begin
            presc_d = presc_q + PrescW'(1);
        end
        if (count_we_i) begin
            presc_d = '0;
            count_d = wdata_i;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
        end
        // Match uses current values; a Compare write beats a same-cycle match.
        ti_d = compare_we_i ? 1'b0 : (ti_q | (count_q == compare_q));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_ext.sv
// Coprocessor 0: exception state, interrupt synchronisation and masking, MTC0/MFC0 access.
module cp0_ext #(
    parameter int unsigned HW_INT_N        = 6,
    parameter int unsigned COUNT_DIV       = 2,
    parameter int unsigned INT_SYNC_STAGES = 2,
    parameter logic [31:0] PRID_VAL        = 32'h0001_8003,
    parameter logic [31:0] CONFIG_VAL      = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [7:0]          cop_address,
    input  logic [31:0]         data_i,
    output logic [31:0]         data_o,
    input  logic [HW_INT_N-1:0] hardware_int,
    input  logic                is_exception,
    input  logic                is_bd,
    input  logic [4:0]          exc_code,
    input  logic [31:0]         exc_pc,
    input  logic                we_badvaddr,
    input  logic [31:0]         badvaddr,
    input  logic                is_excep_return,
    output logic                int_req,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic [31:0]         epc_o
);

    import cp0_pkg::*;

    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [31:0] count, compare;
    logic        ti;

    logic [7:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic        bd_q, bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        int_req_q, int_req_d;

    logic [HW_INT_N-1:0] sync_q [INT_SYNC_STAGES];
    logic [HW_INT_N-1:0] sync_d [INT_SYNC_STAGES];
    logic [5:0]          ip_hw;
    logic [31:0]         status_wr, cause_wr;

    assign wr_count   = we & cp0_hit(cop_address, ADDR_COUNT);
    assign wr_compare = we & cp0_hit(cop_address, ADDR_COMPARE);
    assign wr_status  = we & cp0_hit(cop_address, ADDR_STATUS);
    assign wr_cause   = we & cp0_hit(cop_address, ADDR_CAUSE);
    assign wr_epc     = we & cp0_hit(cop_address, ADDR_EPC);

    cp0_timer #(
        .CountDiv(COUNT_DIV)
    ) u_timer (
        .clk_i       (clk),
        .rst_ni      (rst),
        .count_we_i  (wr_count),
        .compare_we_i(wr_compare),
        .wdata_i     (data_i),
        .count_o     (count),
        .compare_o   (compare),
        .ti_o        (ti)
    );

    always_comb begin
        sync_d[0] = hardware_int;
        for (int i = 1; i < INT_SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // The top interrupt line is shared with the timer interrupt.
    always_comb begin
        ip_hw                 = '0;
        ip_hw[HW_INT_N-1:0]   = sync_q[INT_SYNC_STAGES-1];
        ip_hw[5]              = ip_hw[5] | ti;
    end

    always_comb begin
        status_o                 = STATUS_RST;
        status_o[IM_HI:IM_LO]    = im_q;
        status_o[EXL_BIT]        = exl_q;
        status_o[IE_BIT]         = ie_q;

        cause_o                        = '0;
        cause_o[BD_BIT]                = bd_q;
        cause_o[TI_BIT]                = ti;
        cause_o[IP_H_HI:IP_H_LO]       = ip_hw;
        cause_o[IP_S_HI:IP_S_LO]       = ip_sw_q;
        cause_o[EXCCODE_HI:EXCCODE_LO] = exccode_q;
    end

    assign epc_o   = epc_q;
    assign int_req = int_req_q;

    always_comb begin
        im_d       = im_q;
        ie_d       = ie_q;
        exl_d      = exl_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (wr_status) begin
            im_d  = data_i[IM_HI:IM_LO];
            exl_d = data_i[EXL_BIT];
            ie_d  = data_i[IE_BIT];
        end
        if (wr_cause) begin
            ip_sw_d = data_i[IP_S_HI:IP_S_LO];
        end
        if (wr_epc) begin
            epc_d = data_i;
        end
        if (is_excep_return) begin
            exl_d = 1'b0;
        end
        // Nested exceptions keep the original EPC/BD; an exception also overrides an MTC0 to EPC.
        if (is_exception) begin
            exl_d     = 1'b1;
            exccode_d = exc_code;
            epc_d     = epc_q;
            if (!exl_q) begin
                epc_d = exc_pc;
                bd_d  = is_bd;
            end
            if (we_badvaddr) begin
                badvaddr_d = badvaddr;
            end
        end

        int_req_d = ie_q & ~exl_q & (|(cause_o[IP_H_HI:IP_S_LO] & im_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im_q       <= '0;
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ip_sw_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            int_req_q  <= 1'b0;
            for (int i = 0; i < INT_SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            im_q       <= im_d;
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            int_req_q  <= int_req_d;
            for (int i = 0; i < INT_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    // Reads of a register being written return the merged post-write value.
    always_comb begin
        status_wr                = status_o;
        status_wr[IM_HI:IM_LO]   = data_i[IM_HI:IM_LO];
        status_wr[EXL_BIT]       = data_i[EXL_BIT];
        status_wr[IE_BIT]        = data_i[IE_BIT];
        cause_wr                 = cause_o;
        cause_wr[IP_S_HI:IP_S_LO] = data_i[IP_S_HI:IP_S_LO];

        data_o = '0;
        if (cop_address[2:0] == 3'd0) begin
            case (cop_address[7:3])
                ADDR_BADVADDR: data_o = badvaddr_q;
                ADDR_COUNT:    data_o = we ? data_i : count;
                ADDR_COMPARE:  data_o = we ? data_i : compare;
                ADDR_STATUS:   data_o = we ? status_wr : status_o;
                ADDR_CAUSE:    data_o = we ? cause_wr : cause_o;
                ADDR_EPC:      data_o = we ? data_i : epc_q;
                ADDR_PRID:     data_o = PRID_VAL;
                ADDR_CONFIG:   data_o = CONFIG_VAL;
                default:       data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_ext.sv
// Randomised bench for cp0_ext: register-level reference model plus directed literal checks.
module tb_cp0_ext;

    localparam int unsigned HW_N     = 6;
    localparam int unsigned DIV      = 2;
    localparam int unsigned STAGES   = 2;
    localparam logic [31:0] PRID     = 32'h0001_8003;
    localparam logic [31:0] CONFIG   = 32'h0000_0000;
    localparam logic [31:0] ST_WMASK = 32'h0000_FF03;

    logic            clk;
    logic            rst;
    logic            we;
    logic [7:0]      cop_address;
    logic [31:0]     data_i;
    logic [31:0]     data_o;
    logic [HW_N-1:0] hardware_int;
    logic            is_exception;
    logic            is_bd;
    logic [4:0]      exc_code;
    logic [31:0]     exc_pc;
    logic            we_badvaddr;
    logic [31:0]     badvaddr;
    logic            is_excep_return;
    logic            int_req;
    logic [31:0]     status_o, cause_o, epc_o;

    int checks = 0;
    int errors = 0;

    cp0_ext #(
        .HW_INT_N       (HW_N),
        .COUNT_DIV      (DIV),
        .INT_SYNC_STAGES(STAGES),
        .PRID_VAL       (PRID),
        .CONFIG_VAL     (CONFIG)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .we             (we),
        .cop_address    (cop_address),
        .data_i         (data_i),
        .data_o         (data_o),
        .hardware_int   (hardware_int),
        .is_exception   (is_exception),
        .is_bd          (is_bd),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .we_badvaddr    (we_badvaddr),
        .badvaddr       (badvaddr),
        .is_excep_return(is_excep_return),
        .int_req        (int_req),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register values.
    logic [31:0] m_status;
    logic [31:0] m_cause_sw;   // BD, ExcCode and software IP bits only
    logic [31:0] m_base;       // Count value at last load
    int unsigned m_elapsed;    // clock edges since last load
    logic [31:0] m_compare;
    logic        m_ti;
    logic [31:0] m_epc;
    logic [31:0] m_badv;
    logic        m_irq;
    logic [HW_N-1:0] m_hist [STAGES];

    logic       mt;
    logic [4:0] mr;
    assign mt = we && (cop_address[2:0] == 3'd0);
    assign mr = cop_address[7:3];

    function automatic logic [31:0] m_count_f();
        return m_base + 32'(m_elapsed / DIV);
    endfunction

    function automatic logic [31:0] m_cause_f();
        logic [31:0] c;
        c = m_cause_sw | {16'd0, m_hist[STAGES-1], 10'd0};
        if (m_ti) c = c | 32'h4000_8000;
        return c;
    endfunction

    function automatic logic irq_f();
        logic [31:0] c;
        c = m_cause_f();
        return m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a, input logic w,
                                           input logic [31:0] d);
        logic [4:0] r;
        r = a[7:3];
        if (a[2:0] != 3'd0) return 32'd0;
        case (r)
            5'd8:    return m_badv;
            5'd9:    return w ? d : m_count_f();
            5'd11:   return w ? d : m_compare;
            5'd12:   return w ? ((m_status & ~ST_WMASK) | (d & ST_WMASK)) : m_status;
            5'd13:   return w ? ((m_cause_f() & ~32'h300) | (d & 32'h300)) : m_cause_f();
            5'd14:   return w ? d : m_epc;
            5'd15:   return PRID;
            5'd16:   return CONFIG;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_status   <= 32'h0040_0000;
            m_cause_sw <= '0;
            m_base     <= '0;
            m_elapsed  <= 0;
            m_compare  <= '0;
            m_ti       <= 1'b0;
            m_epc      <= '0;
            m_badv     <= '0;
            m_irq      <= 1'b0;
            for (int i = 0; i < STAGES; i++) m_hist[i] <= '0;
        end else begin
            m_irq <= irq_f();
            m_ti  <= (mt && mr == 5'd11) ? 1'b0 : (m_ti || (m_count_f() == m_compare));
            if (mt && mr == 5'd9) begin
                m_base    <= data_i;
                m_elapsed <= 0;
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
            if (mt && mr == 5'd11) m_compare <= data_i;
            if (mt && mr == 5'd12) m_status <= (m_status & ~ST_WMASK) | (data_i & ST_WMASK);
            if (mt && mr == 5'd13) m_cause_sw[9:8] <= data_i[9:8];
            if (mt && mr == 5'd14 && !is_exception) m_epc <= data_i;
            if (is_excep_return) m_status[1] <= 1'b0;
            if (is_exception) begin
                m_status[1]     <= 1'b1;
                m_cause_sw[6:2] <= exc_code;
                if (!m_status[1]) begin
                    m_epc          <= exc_pc;
                    m_cause_sw[31] <= is_bd;
                end
                if (we_badvaddr) m_badv <= badvaddr;
            end
            m_hist[0] <= hardware_int;
            for (int i = 1; i < STAGES; i++) m_hist[i] <= m_hist[i-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("data_o", data_o, m_read(cop_address, we, data_i));
        chk("status_o", status_o, m_status);
        chk("cause_o", cause_o, m_cause_f());
        chk("epc_o", epc_o, m_epc);
        chk("int_req", {31'd0, int_req}, {31'd0, m_irq});
    end

    function automatic logic [7:0] addr_of(input int r);
        return {r[4:0], 3'b000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input logic [31:0] d);
        we          = 1'b1;
        cop_address = addr_of(r);
        data_i      = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    logic [4:0] rd;
    int         found;

    initial begin
        rst = 1'b0; we = 1'b0; cop_address = '0; data_i = '0; hardware_int = '0;
        is_exception = 1'b0; is_bd = 1'b0; exc_code = '0; exc_pc = '0;
        we_badvaddr = 1'b0; badvaddr = '0; is_excep_return = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Count after reset with a divide-by-2 prescaler: 0,0,1,1,2
        cop_address = addr_of(9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("count_seq", data_o, 32'(i / 2));
            tick();
        end
        chk("reset_epc", epc_o, 32'd0);

        we = 1'b1; data_i = 32'd5;
        @(negedge clk);
        chk("count_bypass", data_o, 32'd5);
        tick();
        we = 1'b0;
        @(negedge clk); chk("count_load", data_o, 32'd5); tick();
        @(negedge clk); chk("count_hold", data_o, 32'd5); tick();
        @(negedge clk); chk("count_inc", data_o, 32'd6); tick();

        // Timer interrupt through IM[7]
        wr(12, 32'h0000_8001);
        wr(11, 32'd10);
        wr(9, 32'd8);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (data_o == 32'd10) found = 1;
            else tick();
        end
        chk("count_reach", data_o, 32'd10);
        chk("ti_before", {31'd0, cause_o[30]}, 32'd0);
        chk("irq_before", {31'd0, int_req}, 32'd0);
        tick();
        @(negedge clk);
        chk("ti_set", {31'd0, cause_o[30]}, 32'd1);
        chk("ip15_ti", {31'd0, cause_o[15]}, 32'd1);
        chk("irq_lag", {31'd0, int_req}, 32'd0);
        tick();
        @(negedge clk); chk("irq_timer", {31'd0, int_req}, 32'd1); tick();
        wr(11, 32'd20);
        @(negedge clk);
        chk("ti_clear", {31'd0, cause_o[30]}, 32'd0);
        chk("irq_hold", {31'd0, int_req}, 32'd1);
        tick();
        @(negedge clk); chk("irq_drop", {31'd0, int_req}, 32'd0); tick();
        wr(12, 32'd0);

        // Hardware interrupt 2 through the synchroniser
        wr(12, 32'h0000_1001);
        hardware_int = 6'b000100;
        @(negedge clk); chk("ip12_0", {31'd0, cause_o[12]}, 32'd0); tick();
        @(negedge clk); chk("ip12_1", {31'd0, cause_o[12]}, 32'd0); tick();
        @(negedge clk);
        chk("ip12_2", {31'd0, cause_o[12]}, 32'd1);
        chk("irq_hw_lag", {31'd0, int_req}, 32'd0);
        tick();
        @(negedge clk); chk("irq_hw", {31'd0, int_req}, 32'd1); tick();
        wr(12, 32'h0000_1003);
        tick();
        @(negedge clk); chk("irq_exl_mask", {31'd0, int_req}, 32'd0); tick();
        @(negedge clk); chk("irq_exl_stay", {31'd0, int_req}, 32'd0); tick();
        hardware_int = '0;
        wr(12, 32'd0);

        // Exception commit, then a nested one
        cop_address = addr_of(8);
        is_exception = 1'b1; exc_pc = 32'hBFC0_0100; is_bd = 1'b1; exc_code = 5'd4;
        we_badvaddr = 1'b1; badvaddr = 32'h0000_1234;
        tick();
        is_exception = 1'b0; we_badvaddr = 1'b0;
        @(negedge clk);
        chk("exc_epc", epc_o, 32'hBFC0_0100);
        chk("exc_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("exc_code", {27'd0, cause_o[6:2]}, 32'd4);
        chk("exc_badv", data_o, 32'h0000_1234);
        chk("exc_exl", {31'd0, status_o[1]}, 32'd1);
        tick();
        is_exception = 1'b1; exc_pc = 32'h8000_0000; is_bd = 1'b0; exc_code = 5'd5;
        tick();
        is_exception = 1'b0;
        @(negedge clk);
        chk("nest_epc", epc_o, 32'hBFC0_0100);
        chk("nest_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("nest_code", {27'd0, cause_o[6:2]}, 32'd5);
        tick();

        // Exception, ERET and MTC0 Status in one cycle
        is_exception = 1'b1; exc_code = 5'd8; is_excep_return = 1'b1;
        we = 1'b1; cop_address = addr_of(12); data_i = 32'd0;
        tick();
        is_exception = 1'b0; is_excep_return = 1'b0; we = 1'b0;
        @(negedge clk); chk("prio_exl", {31'd0, status_o[1]}, 32'd1); tick();
        is_excep_return = 1'b1;
        tick();
        is_excep_return = 1'b0;
        @(negedge clk); chk("eret_exl", status_o, 32'h0040_0000); tick();

        // Cause write only touches IP[9:8]
        wr(11, 32'hFFFF_0000);
        we = 1'b1; cop_address = addr_of(13); data_i = 32'hFFFF_FFFF;
        @(negedge clk); chk("cause_bypass", data_o, 32'h8000_0320); tick();
        we = 1'b0;
        @(negedge clk); chk("cause_wr", cause_o, 32'h8000_0320); tick();

        cop_address = addr_of(15);
        @(negedge clk); chk("prid", data_o, 32'h0001_8003); tick();
        cop_address = addr_of(16);
        @(negedge clk); chk("config", data_o, 32'h0000_0000); tick();
        cop_address = addr_of(0);
        @(negedge clk); chk("addr0", data_o, 32'h0000_0000); tick();
        cop_address = 8'h79;
        @(negedge clk); chk("prid_sel1", data_o, 32'h0000_0000); tick();
        wr(13, 32'd0);

        // Randomised traffic with one asynchronous reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rst = 1'b0; we = 1'b0; is_exception = 1'b0; is_excep_return = 1'b0;
                tick();
                rst = 1'b1;
            end
            case ($urandom_range(0, 9))
                0:       rd = 5'd8;
                1:       rd = 5'd9;
                2:       rd = 5'd11;
                3:       rd = 5'd12;
                4:       rd = 5'd13;
                5:       rd = 5'd14;
                6:       rd = 5'd15;
                7:       rd = 5'd16;
                8:       rd = 5'($urandom_range(0, 31));
                default: rd = 5'd12;
            endcase
            cop_address = {rd, ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0};
            we          = ($urandom_range(0, 3) == 0);
            data_i      = $urandom;
            if (rd == 5'd11 && $urandom_range(0, 1) == 1)
                data_i = m_count_f() + 32'($urandom_range(0, 5));
            if (rd == 5'd12) data_i[1] = ($urandom_range(0, 3) == 0);
            is_exception    = ($urandom_range(0, 15) == 0);
            is_excep_return = ($urandom_range(0, 15) == 0);
            is_bd           = 1'($urandom_range(0, 1));
            exc_code        = 5'($urandom_range(0, 31));
            exc_pc          = $urandom;
            we_badvaddr     = 1'($urandom_range(0, 1));
            badvaddr        = $urandom;
            if ($urandom_range(0, 7) == 0) hardware_int = 6'($urandom);
            tick();
        end
        we = 1'b0; is_exception = 1'b0; is_excep_return = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_ext.md
# cp0_ext

Parametrised next-generation coprocessor-0 for the MIPS core. It holds these CP0 registers:
- BadVAddr, Count, Compare, Status, Cause and EPC;
- read-only PRId and Config.

The block also implements three timing functions: a configurable Count prescaler, hardware-interrupt synchronisation, and a registered interrupt-request output to the pipeline's exception unit. It sits beside the MEM/WB stage: the pipeline performs MTC0/MFC0 and reports exceptions and ERET here.

## Interface
Parameters:
- HW_INT_N, 6, number of hardware interrupt lines, 1..6; Cause.IP[2+HW_INT_N-1:2] populated, rest read 0
- COUNT_DIV, 2, clock cycles per Count increment, >=1
- INT_SYNC_STAGES, 2, synchroniser flops on hw_int, >=1
- PRID_VAL, 32'h0001_8003, PRId read value
- CONFIG_VAL, 32'h0000_0000, Config read value

Ports (one clock, clk; reset rst is asynchronous, active-low):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- we  in  1  MTC0 write strobe
- cop_address  in  8  {rd[4:0], sel[2:0]}
- data_i  in  32  MTC0 data
- data_o  out  32  MFC0 data, combinational, with write bypass
- hardware_int  in  HW_INT_N  asynchronous interrupt lines
- is_exception  in  1  exception commit, 1-cycle pulse
- is_bd  in  1  faulting instruction is in a delay slot
- exc_code  in  5  ExcCode to record
- exc_pc  in  32  EPC candidate
- we_badvaddr  in  1  load BadVAddr with this exception
- badvaddr  in  32  faulting address
- is_excep_return  in  1  ERET commit
- int_req  out  1  registered interrupt request
- status_o, cause_o, epc_o  out  32 each  current register values

## Operation
Register addresses (sel 0): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16. Unmapped addresses read 0 and ignore writes.

Writable fields:
- Status: IM[15:8], EXL[1], IE[0]; BEV[22] is read-only 1.
- Cause: IP[9:8] only (software interrupts).
- Count, Compare, EPC: all 32 bits.
- BadVAddr: written only by exceptions.

Read bypass: when we is high and cop_address matches, data_o returns the post-write value, merged with read-only fields.

Prescaler and Count:
- A prescaler counts 0..COUNT_DIV-1. Count increments as the prescaler wraps to 0, modulo 2^32.
- An MTC0 to Count loads Count and resets the prescaler to 0.

Timer interrupt:
- Cause.TI[30] sets when Count == Compare. It is sticky.
- An MTC0 to Compare clears TI. If the clear and the match occur in the same cycle, the clear wins.

Cause.IP:
- IP[15:10] = synchronised hardware_int.
- IP[15] = hardware_int[5] OR TI, when HW_INT_N = 6; otherwise IP[15] = TI.

int_req (registered) = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), evaluated on current register values.

Exception commit (is_exception):
- ExcCode ← exc_code; Status.EXL ← 1.
- If the old EXL was 0: EPC ← exc_pc and Cause.BD ← is_bd. If the old EXL was 1, EPC and BD are unchanged.
- If we_badvaddr: BadVAddr ← badvaddr.

ERET commit (is_excep_return): Status.EXL ← 0.

Priority for EXL and EPC in a single cycle: is_exception > is_excep_return > MTC0.

## Timing
- Reset values: Status 32'h0040_0000; Cause, Count, Compare, EPC, BadVAddr 0; prescaler 0; synchronisers 0; int_req 0.
- All register updates take effect on the next rising clk edge.
- hardware_int to Cause.IP visible: INT_SYNC_STAGES cycles.
- Cause.IP to int_req: 1 further cycle.
- MTC0 Status or Cause to int_req change: 2 cycles (register update, then int_req flop).
- Count == Compare to TI set: 1 cycle. TI to int_req: 1 further cycle.
- Reset asserted mid-operation immediately forces all reset values; there is no partial-state retention.

## Structure
- Shared package cp0_pkg holds:
  - register address constants;
  - field bit positions (IM, EXL, IE, BD, TI, IP_H, IP_S, EXCCODE, BEV);
  - the Status reset constant.
- One sub-module, cp0_timer, holds the prescaler, Count, Compare and the TI flag. Its inputs are the write strobes and data; its outputs are count, compare and ti. All other logic lives in cp0_ext.

## Test plan
- Reset, COUNT_DIV=2: Count reads 0, 0, 1, 1, 2… Write Count=5 → the next read is 5, and Count becomes 6 after 2 cycles.
- Compare=10, Count=8, Status={IM[7]=1, IE=1}:
  - TI rises the cycle after Count reaches 10, and int_req follows one cycle later.
  - Writing Compare=20 clears TI, and int_req drops 2 cycles after the write.
- hardware_int[2] pulsed high with INT_SYNC_STAGES=2: Cause.IP[12] is set 2 cycles later; with IM[4]=1 and IE=1, int_req follows 1 cycle after that. With EXL=1, int_req stays 0.
- is_exception with exc_pc=0xBFC0_0100, is_bd=1, exc_code=4, we_badvaddr=1, badvaddr=0x1234:
  - EPC=0xBFC0_0100, BD=1, ExcCode=4, BadVAddr=0x1234, EXL=1.
  - A second exception carrying exc_pc=0x8000_0000 leaves EPC unchanged.
- Same cycle: is_exception, is_excep_return, and MTC0 Status with EXL=0 → EXL=1. Then ERET alone → EXL=0.
- MTC0 Cause=0xFFFF_FFFF: only IP[9:8] change; data_o shows the merged value in the write cycle. Reading addresses 15 and 16 returns PRID_VAL and CONFIG_VAL; address 0 reads 0.
